// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: owner encoding,
// arbiter FSM states, default word-address width and command bundle.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 13;

    typedef logic owner_t;
    localparam owner_t OWN_CPU = 1'b0;
    localparam owner_t OWN_LD  = 1'b1;

    typedef enum logic {
        S_CPU_PRI = 1'b0,
        S_LD_PRI  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dmem_cmd_t;

endpackage

// File: rtl/dmem_resp_track.sv
// Read-response tracker: remembers who issued the last granted read
// and steers the 1-cycle-latency memory read data back to that port.
//   clk, rst       : clock, synchronous active-high reset
//   rd_fire_i      : a read was granted this cycle
//   owner_i        : which port owns that read
//   mem_rdata_i    : read data from the lane RAMs
//   cpu_r*/ld_r*   : per-port response valid and data
module dmem_resp_track
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_fire_i,
    input  owner_t      owner_i,
    input  logic [31:0] mem_rdata_i,
    output logic        cpu_rvalid_o,
    output logic [31:0] cpu_rdata_o,
    output logic        ld_rvalid_o,
    output logic [31:0] ld_rdata_o
);

    logic   valid_q;
    logic   valid_d;
    owner_t owner_q;
    owner_t owner_d;

    always_comb begin
        valid_d = rd_fire_i;
        owner_d = rd_fire_i ? owner_i : owner_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            owner_q <= OWN_CPU;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    assign cpu_rvalid_o = valid_q & (owner_q == OWN_CPU);
    assign ld_rvalid_o  = valid_q & (owner_q == OWN_LD);

    // Non-owner sees zero so stale words never leak across ports.
    assign cpu_rdata_o = cpu_rvalid_o ? mem_rdata_i : 32'h0;
    assign ld_rdata_o  = ld_rvalid_o  ? mem_rdata_i : 32'h0;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: shares one word port between the CPU
// MEM stage and the loader, with starvation-bounded CPU priority.
//   cpu_* : CPU request/grant/response port, cpu_stall to hazard unit
//   ld_*  : loader request/grant/response port
//   mem_* : word address, data, lane write enables, read enable, rdata
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    input  logic [3:0]        ld_wstrb,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wren,
    output logic              mem_rden,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    arb_state_t state_q;
    logic [7:0] starve_q;
    logic [7:0] starve_d;
    logic [7:0] starve_inc;

    dmem_cmd_t  cpu_cmd;
    dmem_cmd_t  ld_cmd;
    dmem_cmd_t  sel_cmd;
    logic       any_gnt;
    logic       rd_fire;
    owner_t     rd_owner;

    assign cpu_cmd = '{we: cpu_we, addr: cpu_addr,
                       wdata: cpu_wdata, wstrb: cpu_wstrb};
    assign ld_cmd  = '{we: ld_we, addr: ld_addr,
                       wdata: ld_wdata, wstrb: ld_wstrb};

    // CPU wins unless the loader currently holds priority and asks.
    assign cpu_gnt   = cpu_req & ((state_q == S_CPU_PRI) | ~ld_req);
    assign ld_gnt    = ld_req & ~cpu_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign any_gnt   = cpu_gnt | ld_gnt;

    always_comb begin
        sel_cmd = '0;
        unique case (1'b1)
            cpu_gnt: sel_cmd = cpu_cmd;
            ld_gnt:  sel_cmd = ld_cmd;
            default: sel_cmd = '0;
        endcase
    end

    assign mem_addr  = sel_cmd.addr[ADDR_W+1:2];
    assign mem_wdata = sel_cmd.wdata;
    assign mem_wren  = sel_cmd.we ? sel_cmd.wstrb : 4'b0000;
    assign mem_rden  = any_gnt & ~sel_cmd.we;

    // Byte offset and bits above the RAM range are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sel_cmd.addr[31:ADDR_W+2],
                                sel_cmd.addr[1:0]};

    assign rd_fire  = mem_rden;
    assign rd_owner = ld_gnt ? OWN_LD : OWN_CPU;

    // Saturating count of consecutive denied loader cycles.
    assign starve_inc = (starve_q >= LIMIT) ? LIMIT
                                            : starve_q + 8'd1;

    always_comb begin
        starve_d = starve_q;
        if (ld_gnt) begin
            starve_d = 8'd0;
        end else if (ld_req) begin
            starve_d = starve_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_CPU_PRI;
            starve_q <= 8'd0;
        end else begin
            starve_q <= starve_d;
            unique case (state_q)
                S_CPU_PRI: begin
                    if (ld_req && !ld_gnt && starve_inc == LIMIT) begin
                        state_q <= S_LD_PRI;
                    end
                end
                S_LD_PRI: begin
                    // One forced loader access, then back to CPU priority.
                    if (ld_gnt || !ld_req) begin
                        state_q <= S_CPU_PRI;
                    end
                end
                default: state_q <= S_CPU_PRI;
            endcase
        end
    end

    dmem_resp_track u_resp (
        .clk          (clk),
        .rst          (rst),
        .rd_fire_i    (rd_fire),
        .owner_i      (rd_owner),
        .mem_rdata_i  (mem_rdata),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_rdata_o  (cpu_rdata),
        .ld_rvalid_o  (ld_rvalid),
        .ld_rdata_o   (ld_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small
// read-only lane RAM model returning data one cycle after mem_rden.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_gnt, cpu_rvalid, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        ld_req, ld_we;
    logic [31:0] ld_addr, ld_wdata;
    logic [3:0]  ld_wstrb;
    logic        ld_gnt, ld_rvalid;
    logic [31:0] ld_rdata;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wren;
    logic        mem_rden;
    logic [31:0] mem_rdata = 32'h0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(13), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_wstrb(ld_wstrb),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_rden(mem_rden),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] rom(input logic [12:0] a);
        case (a)
            13'd4:   rom = 32'hDEADBEEF;
            13'd5:   rom = 32'hCAFEF00D;
            13'd6:   rom = 32'h0BADC0DE;
            default: rom = 32'h5A5A0000 | 32'(a);
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_rden) mem_rdata <= rom(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0;
        cpu_wdata = 0; cpu_wstrb = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0;
        ld_wdata = 0; ld_wstrb = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        cyc();
        cyc();
        #1;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
        chk("rst_ld_gnt", 32'(ld_gnt), 0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_ld_rvalid", 32'(ld_rvalid), 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_cmd", {mem_wdata[18:0], mem_addr},
            0);
        chk("rst_mem_en", {27'd0, mem_wren, mem_rden}, 0);
        chk("rst_state", 32'(dut.state_q), 32'(S_CPU_PRI));
        chk("rst_starve", 32'(dut.starve_q), 0);
        rst = 0;

        // CPU read of word 4
        cyc();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0010;
        #1;
        chk("rd_cpu_gnt", 32'(cpu_gnt), 1);
        chk("rd_mem_addr", 32'(mem_addr), 4);
        chk("rd_mem_rden", 32'(mem_rden), 1);
        chk("rd_mem_wren", 32'(mem_wren), 0);
        chk("rd_stall", 32'(cpu_stall), 0);
        cyc();
        idle();
        #1;
        chk("rd_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_ld_rvalid", 32'(ld_rvalid), 0);
        chk("rd_ld_rdata", ld_rdata, 0);

        // CPU store with upper-half strobes
        cyc();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_0008;
        cpu_wdata = 32'h1122_3344; cpu_wstrb = 4'b1100;
        #1;
        chk("wr_gnt", 32'(cpu_gnt), 1);
        chk("wr_wren", 32'(mem_wren), 32'hC);
        chk("wr_addr", 32'(mem_addr), 2);
        chk("wr_wdata", mem_wdata, 32'h1122_3344);
        chk("wr_rden", 32'(mem_rden), 0);
        cyc();
        idle();
        #1;
        chk("wr_no_rvalid", {30'd0, cpu_rvalid, ld_rvalid}, 0);

        // Contention: CPU wins, then LD gets the slot
        cyc();
        cpu_req = 1; cpu_addr = 32'h0000_0014;
        ld_req = 1; ld_addr = 32'h0000_0018;
        #1;
        chk("ct_cpu_gnt", 32'(cpu_gnt), 1);
        chk("ct_ld_gnt", 32'(ld_gnt), 0);
        chk("ct_stall", 32'(cpu_stall), 0);
        chk("ct_addr", 32'(mem_addr), 5);
        cyc();
        cpu_req = 0;
        #1;
        chk("ct_ld_gnt2", 32'(ld_gnt), 1);
        chk("ct_addr2", 32'(mem_addr), 6);
        chk("ct_cpu_rdata", cpu_rdata, 32'hCAFEF00D);
        cyc();
        idle();
        #1;
        chk("ct_ld_rvalid", 32'(ld_rvalid), 1);
        chk("ct_ld_rdata", ld_rdata, 32'h0BADC0DE);
        chk("ct_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("ct_starve", 32'(dut.starve_q), 0);

        // Starvation: forced LD grant on the ninth cycle
        cpu_req = 1; cpu_addr = 32'h0000_0010;
        ld_req = 1; ld_addr = 32'h0000_0014;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("sv_ld_gnt_c%0d", c),
                32'(ld_gnt), (c == 8) ? 1 : 0);
            chk($sformatf("sv_cpu_gnt_c%0d", c),
                32'(cpu_gnt), (c == 8) ? 0 : 1);
            chk($sformatf("sv_stall_c%0d", c),
                32'(cpu_stall), (c == 8) ? 1 : 0);
            cyc();
        end
        idle();

        // Back-to-back: CPU read, LD read, CPU write
        cyc();
        cpu_req = 1; cpu_addr = 32'h0000_0010;
        cyc();
        idle();
        ld_req = 1; ld_addr = 32'h0000_0014;
        #1;
        chk("bb_ld_gnt", 32'(ld_gnt), 1);
        chk("bb_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("bb_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("bb_ld_rvalid0", 32'(ld_rvalid), 0);
        cyc();
        idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_000C;
        cpu_wdata = 32'hA5A5_5A5A; cpu_wstrb = 4'b1111;
        #1;
        chk("bb_wr_wren", 32'(mem_wren), 32'hF);
        chk("bb_ld_rvalid", 32'(ld_rvalid), 1);
        chk("bb_ld_rdata", ld_rdata, 32'hCAFEF00D);
        chk("bb_cpu_rvalid1", 32'(cpu_rvalid), 0);
        cyc();
        idle();
        #1;
        chk("bb_quiet", {30'd0, cpu_rvalid, ld_rvalid}, 0);

        // Zero-strobe write is a granted no-op
        cyc();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_0020;
        cpu_wstrb = 4'b0000;
        #1;
        chk("z_gnt", 32'(cpu_gnt), 1);
        chk("z_en", {27'd0, mem_wren, mem_rden}, 0);
        cyc();
        idle();
        #1;
        chk("z_no_rvalid", 32'(cpu_rvalid), 0);

        // Reset with a read in flight
        cyc();
        cpu_req = 1; cpu_addr = 32'h0000_0010;
        ld_req = 1; ld_addr = 32'h0000_0018;
        cyc();
        #1;
        chk("rr_starve_pre", 32'(dut.starve_q), 1);
        rst = 1;
        #1;
        chk("rr_gnt", 32'(cpu_gnt), 1);
        cyc();
        idle();
        #1;
        chk("rr_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rr_state", 32'(dut.state_q), 32'(S_CPU_PRI));
        chk("rr_starve", 32'(dut.starve_q), 0);
        rst = 0;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the byte-lane data memory. It shares one 32-bit data-memory port between the pipeline MEM stage (CPU port) and a program/debug loader port (LD port). It issues one word access per cycle with per-byte write strobes and routes 1-cycle-latency read data back to the owning requester. It sits between `memory_stage` and the lane RAMs, and drives `cpu_stall` into the hazard unit when the CPU loses arbitration.

## Interface
Parameters:
- `ADDR_W`, 13 — word-address width of the data memory.
- `STARVE_LIMIT`, 8 — consecutive denied LD-request cycles that force one LD grant. Legal range 1–255.

Ports:
- `clk`  in  1  — single clock, all state on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `cpu_req`  in  1  — CPU access request; held until granted.
- `cpu_we`  in  1  — 1 = write, 0 = read.
- `cpu_addr`  in  32  — byte address; bits `[ADDR_W+1:2]` select the word.
- `cpu_wdata`  in  32  — write data, already lane-aligned.
- `cpu_wstrb`  in  4  — byte-lane write enables (bit i = lane i).
- `cpu_gnt`  out  1  — request accepted this cycle (combinational).
- `cpu_rvalid`  out  1  — read data valid for the CPU.
- `cpu_rdata`  out  32  — read word.
- `cpu_stall`  out  1  — `cpu_req & ~cpu_gnt`.
- `ld_req`, `ld_we`, `ld_addr[31:0]`, `ld_wdata[31:0]`, `ld_wstrb[3:0]`, `ld_gnt`, `ld_rvalid`, `ld_rdata[31:0]` — loader port; same meaning and directions as the CPU port.
- `mem_addr`  out  ADDR_W  — word address to the lane RAMs.
- `mem_wdata`  out  32  — write data to the lanes.
- `mem_wren`  out  4  — per-lane write enables.
- `mem_rden`  out  1  — read enable.
- `mem_rdata`  in  32  — read data; valid the cycle after `mem_rden`.

## Operation
- FSM states:
  - `S_CPU_PRI` (reset state): CPU wins whenever `cpu_req`=1; LD is granted only when `cpu_req`=0.
  - `S_LD_PRI`: LD wins whenever `ld_req`=1; the CPU is granted only when `ld_req`=0.
- Starve counter `starve_cnt` (8-bit):
  - Increments each cycle with `ld_req & ~ld_gnt`.
  - Clears on any `ld_gnt`.
  - Saturates at `STARVE_LIMIT`.
- Transitions:
  - `S_CPU_PRI`→`S_LD_PRI` when the incremented count reaches `STARVE_LIMIT`.
  - `S_LD_PRI`→`S_CPU_PRI` on the first `ld_gnt` in that state, or when `ld_req` drops.
- At most one grant per cycle; `cpu_gnt & ld_gnt` is never 1.
- Command path (combinational from the granted port):
  - `mem_addr` = granted `addr[ADDR_W+1:2]`.
  - `mem_wdata` = granted `wdata`.
  - `mem_wren` = `wstrb` if `we`=1, else 0.
  - `mem_rden` = ~`we`.
  - With no grant, all memory command outputs are 0.
- Read writes with `wstrb`=0 are legal no-ops: they get a grant, `mem_wren`=0, and no response.
- Response tracking:
  - Registered `resp_valid` and `resp_owner` are captured on every granted read.
  - The next cycle drives `X_rvalid`=1 and `X_rdata`=`mem_rdata` for the owner only.
  - The non-owner's rdata is 0.
  - Writes produce no response.
- Address bits `[1:0]` and bits above `ADDR_W+1` are ignored. Sub-word alignment and sign extension belong to the requester.

## Timing
- Grant and memory command: same cycle as an eligible request (0-cycle arbitration).
- Read latency: `rvalid` exactly 1 cycle after the granting cycle. Back-to-back reads give `rvalid` on consecutive cycles.
- Read then write in consecutive cycles: the write proceeds while the read response is returned. There is no turnaround bubble.
- Worst-case LD wait under continuous CPU requests: `STARVE_LIMIT` cycles, then granted on cycle `STARVE_LIMIT`+1.
- Reset: values after the reset edge:
  - FSM = `S_CPU_PRI`, `starve_cnt` = 0, `resp_valid` = 0.
  - All `gnt`, `rvalid`, `rdata`, and `mem_*` outputs = 0, given requests are 0.
- Reset while a read is outstanding: the response is dropped and `rvalid` is 0 in the following cycle.
- Simultaneous requests with `starve_cnt` < `STARVE_LIMIT`: the CPU wins.

## Structure
- Shared package `dmem_pkg`:
  - Owner encoding `OWN_CPU`=1'b0, `OWN_LD`=1'b1.
  - FSM state encoding.
  - Default `ADDR_W`.
- Sub-module `dmem_resp_track`: the owner/valid register and read-data demux.
- The arbiter FSM, starve counter, and command mux stay in `dmem_arbiter`.

## Test plan
- CPU-only: read 0x0000_0010 (mem word 4 = 0xDEADBEEF) → `cpu_gnt`=1 same cycle, `mem_addr`=4, `mem_rden`=1; next cycle `cpu_rvalid`=1, `cpu_rdata`=0xDEADBEEF, `ld_rvalid`=0.
- Store strobes: CPU write addr 0x8, wdata 0x1122_3344, wstrb 4'b1100 → `mem_wren`=4'b1100, `mem_addr`=2, no `rvalid`.
- Contention: `cpu_req` and `ld_req` both high → `cpu_gnt`=1, `ld_gnt`=0, `cpu_stall`=0; CPU drops → `ld_gnt`=1 the same cycle.
- Starvation: CPU requests continuously, LD requests from cycle 0, `STARVE_LIMIT`=8 → `ld_gnt`=1 on cycle 8, `cpu_stall`=1 that cycle, CPU regains the grant on cycle 9.
- Back-to-back mixed: CPU read, LD read, CPU write in cycles 0–2 → `cpu_rvalid` at cycle 1, `ld_rvalid` at cycle 2, each with its own word.
- Reset mid-read: `rst`=1 in the cycle after a granted read → `cpu_rvalid`=0 and state back to `S_CPU_PRI` with `starve_cnt`=0.
